regfile_sched: RTL and testbench

//  Two-requester scheduler for the 4x4-bit register file (REGISTER): arbitrates requester 0
//  (core) and requester 1 (debug/loader), sequences READ/WRITE/MOVE/SWAP onto the file's

---
 rtl/regfile_sched.sv | 180 ++++++++++++++++++
 tb/tb_regfile_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sched.sv
// regfile_sched: two-requester scheduler for a 4x4-bit register file.
// Arbitrates requester 0 (core) and requester 1 (debug/loader). It sequences
// READ/WRITE/MOVE/SWAP onto the file's single write path (rf_in/rf_main_sel)
// and its read path (rf_sub_sel). The file writes reg[rf_main_sel] on every
// clock, so rf_in loops rf_main_out back whenever no write is intended.
// Optional feature: define REGFILE_SCHED_SWAP_EN to execute SWAP. Without it,
// SWAP is a no-change hold that returns rdata = 0.
//
// state | meaning
// IDLE  | selects r0 and holds it; arbitrates and latches a new request
// EXEC  | performs READ/WRITE/MOVE, or captures reg[dst] for SWAP
// SWAP2 | reg[dst] <= reg[src]
// SWAP3 | reg[src] <= saved reg[dst]
// DONE  | pulses ack for the granted requester, then returns to IDLE
module regfile_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [1:0] dst0,
  input  logic [1:0] dst1,
  input  logic [1:0] src0,
  input  logic [1:0] src1,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic [3:0] rdata0,
  output logic [3:0] rdata1,
  output logic       busy,
  output logic [3:0] rf_in,
  output logic [1:0] rf_main_sel,
  output logic [1:0] rf_sub_sel,
  input  logic [3:0] rf_main_out,
  input  logic [3:0] rf_sub_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
`ifdef REGFILE_SCHED_SWAP_EN
  localparam logic [2:0] S_SWAP2 = 3'd2;
  localparam logic [2:0] S_SWAP3 = 3'd3;
`endif
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  logic [2:0] state, state_nxt;
  logic [1:0] op_q, dst_q, src_q;
  logic [3:0] data_q;
  logic       gnt_q;
  logic       prio_q;
  logic       any_req;
  logic       gnt_sel;
`ifdef REGFILE_SCHED_SWAP_EN
  logic [3:0] tmp_q;
`endif

  assign any_req = req0 | req1;
  // With both requesting, the priority holder wins; otherwise whoever asks.
  assign gnt_sel = (req0 & req1) ? prio_q : req1;
  assign busy    = (state != S_IDLE);

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (any_req) state_nxt = S_EXEC;
`ifdef REGFILE_SCHED_SWAP_EN
      S_EXEC:  state_nxt = (op_q == OP_SWAP) ? S_SWAP2 : S_DONE;
      S_SWAP2: state_nxt = S_SWAP3;
      S_SWAP3: state_nxt = S_DONE;
`else
      S_EXEC:  state_nxt = S_DONE;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Register-file control: hold by default, write only in an active write cycle.
  always_comb begin
    rf_main_sel = 2'b00;
    rf_sub_sel  = 2'b00;
    rf_in       = rf_main_out;
    case (state)
      S_EXEC: begin
        rf_main_sel = dst_q;
        rf_sub_sel  = src_q;
        case (op_q)
          OP_WRITE: rf_in = data_q;
          OP_MOVE:  rf_in = rf_sub_out;
          default:  rf_in = rf_main_out;
        endcase
      end
`ifdef REGFILE_SCHED_SWAP_EN
      S_SWAP2: begin
        rf_main_sel = dst_q;
        rf_sub_sel  = src_q;
        rf_in       = rf_sub_out;
      end
      S_SWAP3: begin
        rf_main_sel = src_q;
        rf_sub_sel  = src_q;
        rf_in       = tmp_q;
      end
`endif
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Latch the granted request and hand priority to the other requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= 2'b00;
      dst_q  <= 2'b00;
      src_q  <= 2'b00;
      data_q <= 4'h0;
      gnt_q  <= 1'b0;
      prio_q <= 1'b0;
    end else if (state == S_IDLE && any_req) begin
      op_q   <= gnt_sel ? op1   : op0;
      dst_q  <= gnt_sel ? dst1  : dst0;
      src_q  <= gnt_sel ? src1  : src0;
      data_q <= gnt_sel ? data1 : data0;
      gnt_q  <= gnt_sel;
      prio_q <= ~gnt_sel;
    end
  end

  // Read results, captured at the end of EXEC for the granted requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0 <= 4'h0;
      rdata1 <= 4'h0;
    end else if (state == S_EXEC) begin
      if (op_q == OP_READ) begin
        if (gnt_q) rdata1 <= rf_sub_out;
        else       rdata0 <= rf_sub_out;
      end
`ifndef REGFILE_SCHED_SWAP_EN
      else if (op_q == OP_SWAP) begin
        if (gnt_q) rdata1 <= 4'h0;
        else       rdata0 <= 4'h0;
      end
`endif
    end
  end

`ifdef REGFILE_SCHED_SWAP_EN
  // Old reg[dst] is saved here so SWAP3 can write it into reg[src].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                tmp_q <= 4'h0;
    else if (state == S_EXEC && op_q == OP_SWAP) tmp_q <= rf_main_out;
  end
`endif

  // Registered ack pulse, high exactly while in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      ack0 <= (state_nxt == S_DONE) && !gnt_q;
      ack1 <= (state_nxt == S_DONE) &&  gnt_q;
    end
  end

endmodule

// File: tb/tb_regfile_sched.sv
// tb_regfile_sched: directed bench for regfile_sched with a behavioural 4x4 register file.
module tb_regfile_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = '0, op1 = '0, dst0 = '0, dst1 = '0, src0 = '0, src1 = '0;
  logic [3:0] data0 = '0, data1 = '0;
  logic       ack0, ack1, busy;
  logic [3:0] rdata0, rdata1, rf_in, rf_main_out, rf_sub_out;
  logic [1:0] rf_main_sel, rf_sub_sel;
  logic [3:0] rf [4];

  int checks = 0;
  int errors = 0;

  regfile_sched dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1), .dst0(dst0), .dst1(dst1),
    .src0(src0), .src1(src1), .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .rf_in(rf_in), .rf_main_sel(rf_main_sel),
    .rf_sub_sel(rf_sub_sel), .rf_main_out(rf_main_out), .rf_sub_out(rf_sub_out)
  );

  always #5 clk = ~clk;

  // Register file: writes reg[main_sel] from rf_in on every clock edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
    end else begin
      rf[rf_main_sel] <= rf_in;
    end
  end
  assign rf_main_out = rf[rf_main_sel];
  assign rf_sub_out  = rf[rf_sub_sel];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and count cycles until its ack is seen (-1 on timeout).
  task automatic run_op(input bit who, input logic [1:0] op, input logic [1:0] dst,
                        input logic [1:0] src, input logic [3:0] data, output int lat);
    if (who) begin op1 = op; dst1 = dst; src1 = src; data1 = data; req1 = 1'b1; end
    else     begin op0 = op; dst0 = dst; src0 = src; data0 = data; req0 = 1'b1; end
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if ((who ? ack1 : ack0) === 1'b1) begin lat = c; break; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
  endtask

  // Both requesters write in the same cycle; records the cycle each ack shows.
  task automatic both_write(input logic [1:0] d0, input logic [3:0] v0,
                            input logic [1:0] d1, input logic [3:0] v1,
                            output int c0, output int c1);
    op0 = 2'b01; dst0 = d0; data0 = v0;
    op1 = 2'b01; dst1 = d1; data1 = v1;
    req0 = 1'b1; req1 = 1'b1;
    c0 = -1; c1 = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (ack0 === 1'b1) begin c0 = c; req0 = 1'b0; end
      if (ack1 === 1'b1) begin c1 = c; req1 = 1'b0; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b%b expected 00", ack0, ack1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rdata0 !== 4'h0 || rdata1 !== 4'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", rdata0, rdata1); end
    checks++; if (rf_main_sel !== 2'b00 || rf_sub_sel !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b/%b expected 00/00", rf_main_sel, rf_sub_sel); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    int lat;
    op0 = 2'b01; dst0 = 2'd2; data0 = 4'hA; req0 = 1'b1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_exec: got %b expected 1", busy); end
    step();
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL write_lat: ack0 %b at cycle 2, expected 1", ack0); end
    req0 = 1'b0;
    step();
    checks++; if (rf[2] !== 4'hA) begin errors++; $display("FAIL write_r2: got %h expected a", rf[2]); end
    run_op(1'b0, 2'b00, 2'd0, 2'd2, 4'h0, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL read_lat: got %0d expected 2", lat); end
    checks++; if (rdata0 !== 4'hA) begin errors++; $display("FAIL read_rdata0: got %h expected a", rdata0); end
  endtask

  task automatic test_idle_hold();
    int lat;
    for (int i = 0; i < 4; i++) run_op(1'b1, 2'b01, 2'(i), 2'd0, 4'(i + 1), lat);
    repeat (20) step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (rf[i] !== 4'(i + 1)) begin errors++; $display("FAIL hold_r%0d: got %h expected %h", i, rf[i], 4'(i + 1)); end
    end
    run_op(1'b1, 2'b00, 2'd0, 2'd3, 4'h0, lat);
    checks++; if (rdata1 !== 4'h4) begin errors++; $display("FAIL hold_read_r3: got %h expected 4", rdata1); end
  endtask

  task automatic test_priority();
    int c0, c1, lat;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    both_write(2'd0, 4'h5, 2'd0, 4'h9, c0, c1);
    checks++; if (c0 !== 2) begin errors++; $display("FAIL prio_ack0_cycle: got %0d expected 2", c0); end
    checks++; if (c1 !== 5) begin errors++; $display("FAIL prio_ack1_cycle: got %0d expected 5", c1); end
    checks++; if (rf[0] !== 4'h9) begin errors++; $display("FAIL prio_order_r0: got %h expected 9", rf[0]); end
    run_op(1'b0, 2'b01, 2'd2, 2'd0, 4'h1, lat);
    both_write(2'd1, 4'h3, 2'd1, 4'h8, c0, c1);
    checks++; if (c1 !== 2 || c0 !== 5) begin errors++; $display("FAIL prio_alternate: got ack1@%0d ack0@%0d expected ack1@2 ack0@5", c1, c0); end
    checks++; if (rf[1] !== 4'h3) begin errors++; $display("FAIL prio_alt_r1: got %h expected 3", rf[1]); end
  endtask

  task automatic test_move();
    int lat;
    run_op(1'b0, 2'b01, 2'd0, 2'd0, 4'h2, lat);
    run_op(1'b0, 2'b01, 2'd1, 2'd0, 4'h5, lat);
    run_op(1'b0, 2'b01, 2'd2, 2'd0, 4'h7, lat);
    run_op(1'b0, 2'b01, 2'd3, 2'd0, 4'h9, lat);
    run_op(1'b1, 2'b10, 2'd3, 2'd1, 4'hF, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL move_lat: got %0d expected 2", lat); end
    checks++; if ({rf[3], rf[2], rf[1], rf[0]} !== 16'h5752) begin errors++; $display("FAIL move_regs: got %h%h%h%h expected 5752", rf[3], rf[2], rf[1], rf[0]); end
    run_op(1'b0, 2'b10, 2'd2, 2'd2, 4'h0, lat);
    checks++; if ({rf[3], rf[2], rf[1], rf[0]} !== 16'h5752) begin errors++; $display("FAIL move_self: got %h%h%h%h expected 5752", rf[3], rf[2], rf[1], rf[0]); end
  endtask

  task automatic test_swap();
    int lat;
    run_op(1'b0, 2'b01, 2'd0, 2'd0, 4'h3, lat);
    run_op(1'b0, 2'b01, 2'd2, 2'd0, 4'hC, lat);
    run_op(1'b0, 2'b00, 2'd0, 2'd2, 4'h0, lat);
    checks++; if (rdata0 !== 4'hC) begin errors++; $display("FAIL swap_pre_read: got %h expected c", rdata0); end
    run_op(1'b0, 2'b11, 2'd0, 2'd2, 4'h0, lat);
`ifdef REGFILE_SCHED_SWAP_EN
    checks++; if (lat !== 4) begin errors++; $display("FAIL swap_lat: got %0d expected 4", lat); end
    checks++; if (rf[0] !== 4'hC || rf[2] !== 4'h3) begin errors++; $display("FAIL swap_regs: got r0=%h r2=%h expected c/3", rf[0], rf[2]); end
    checks++; if (rf[1] !== 4'h5 || rf[3] !== 4'h5) begin errors++; $display("FAIL swap_others: got r1=%h r3=%h expected 5/5", rf[1], rf[3]); end
    run_op(1'b1, 2'b11, 2'd1, 2'd1, 4'h0, lat);
    checks++; if (rf[1] !== 4'h5) begin errors++; $display("FAIL swap_self: got %h expected 5", rf[1]); end
`else
    checks++; if (lat !== 2) begin errors++; $display("FAIL swap_lat: got %0d expected 2", lat); end
    checks++; if (rf[0] !== 4'h3 || rf[2] !== 4'hC) begin errors++; $display("FAIL swap_regs: got r0=%h r2=%h expected 3/c", rf[0], rf[2]); end
    checks++; if (rdata0 !== 4'h0) begin errors++; $display("FAIL swap_rdata: got %h expected 0", rdata0); end
`endif
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    op0 = 2'b11; dst0 = 2'd0; src0 = 2'd2; req0 = 1'b1;
    step();
`ifdef REGFILE_SCHED_SWAP_EN
    step();
`endif
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    reset = 1'b0;
    req0 = 1'b0;
    #1;
    checks++; if (ack0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_outs: got ack0=%b busy=%b expected 0/0", ack0, busy); end
    checks++; if ({rf[3], rf[2], rf[1], rf[0]} !== 16'h0000) begin errors++; $display("FAIL mid_reset_regs: got %h%h%h%h expected 0000", rf[3], rf[2], rf[1], rf[0]); end
    step();
    reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin step(); if (ack0 === 1'b1 || ack1 === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_ack: got ack after abort, expected none"); end
    run_op(1'b0, 2'b01, 2'd3, 2'd0, 4'hB, lat);
    checks++; if (lat !== 2 || rf[3] !== 4'hB) begin errors++; $display("FAIL mid_recover: got lat=%0d r3=%h expected 2/b", lat, rf[3]); end
    run_op(1'b1, 2'b00, 2'd0, 2'd3, 4'h0, lat);
    checks++; if (rdata1 !== 4'hB) begin errors++; $display("FAIL mid_read: got %h expected b", rdata1); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_idle_hold();
    test_priority();
    test_move();
    test_swap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
